// File: rtl/alu_result_display.sv
// Registered 7-segment display path for the signed 8-bit ALU result.
// A start pulse captures the value; a double-dabble engine builds BCD, then four digits are registered.
module alu_result_display #(
    parameter bit ACTIVE_LOW    = 1'b1,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] result,
    output logic       busy,
    output logic       done,
    output logic [0:6] led_dau,
    output logic [0:6] led_hund,
    output logic [0:6] led_tens,
    output logic [0:6] led_unit
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        UPDATE = 2'd2
    } state_t;

    // Glyph codes beyond the decimal digits
    localparam logic [3:0] GLYPH_DASH  = 4'hA;
    localparam logic [3:0] GLYPH_BLANK = 4'hF;

    localparam logic [0:6] SEG_BLANK = ACTIVE_LOW ? 7'b1111111 : 7'b0000000;

    state_t      state;
    logic        sign;
    logic [7:0]  mag;
    logic [11:0] bcd;
    logic [2:0]  iter;

    logic [11:0] bcd_adj;
    logic [19:0] shifted;

    logic [3:0]  hund_d;
    logic [3:0]  tens_d;
    logic [3:0]  unit_d;
    logic        hund_blank;
    logic        tens_blank;
    logic        show_minus;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    // Active-high abcdefg pattern, index 0 = segment a
    function automatic logic [0:6] encode(input logic [3:0] g);
        logic [0:6] p;
        case (g)
            4'd0:        p = 7'b1111110;
            4'd1:        p = 7'b0110000;
            4'd2:        p = 7'b1101101;
            4'd3:        p = 7'b1111001;
            4'd4:        p = 7'b0110011;
            4'd5:        p = 7'b1011011;
            4'd6:        p = 7'b1011111;
            4'd7:        p = 7'b1110000;
            4'd8:        p = 7'b1111111;
            4'd9:        p = 7'b1111011;
            GLYPH_DASH:  p = 7'b0000001;
            default:     p = 7'b0000000;
        endcase
        return ACTIVE_LOW ? ~p : p;
    endfunction

    always_comb begin
        bcd_adj = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};
        shifted = {bcd_adj, mag} << 1;
    end

    always_comb begin
        hund_d     = bcd[11:8];
        tens_d     = bcd[7:4];
        unit_d     = bcd[3:0];
        hund_blank = BLANK_LEADING && (hund_d == 4'd0);
        tens_blank = BLANK_LEADING && (hund_d == 4'd0) && (tens_d == 4'd0);
        // A zero magnitude is never displayed as negative
        show_minus = sign && (bcd != 12'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            sign     <= 1'b0;
            mag      <= 8'd0;
            bcd      <= 12'd0;
            iter     <= 3'd0;
            led_dau  <= SEG_BLANK;
            led_hund <= SEG_BLANK;
            led_tens <= SEG_BLANK;
            led_unit <= SEG_BLANK;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sign  <= result[7];
                        // -128 negates to 8'h80, which is exactly 128 unsigned
                        mag   <= result[7] ? (~result + 8'd1) : result;
                        bcd   <= 12'd0;
                        iter  <= 3'd0;
                        busy  <= 1'b1;
                        state <= CONV;
                    end
                end
                CONV: begin
                    bcd  <= shifted[19:8];
                    mag  <= shifted[7:0];
                    iter <= iter + 3'd1;
                    if (iter == 3'd7) begin
                        state <= UPDATE;
                    end
                end
                UPDATE: begin
                    led_dau  <= encode(show_minus ? GLYPH_DASH : GLYPH_BLANK);
                    led_hund <= encode(hund_blank ? GLYPH_BLANK : hund_d);
                    led_tens <= encode(tens_blank ? GLYPH_BLANK : tens_d);
                    led_unit <= encode(unit_d);
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_result_display.sv
// Directed bench for alu_result_display: vector table plus hand-written multi-cycle sequences.
module tb_alu_result_display;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] result = 8'd0;

    logic       busy, done, busy0, done0;
    logic [0:6] led_dau, led_hund, led_tens, led_unit;
    logic [0:6] led_dau0, led_hund0, led_tens0, led_unit0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_result_display u_dut (
        .clk(clk), .rst(rst), .start(start), .result(result),
        .busy(busy), .done(done),
        .led_dau(led_dau), .led_hund(led_hund), .led_tens(led_tens), .led_unit(led_unit)
    );

    alu_result_display #(.ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b0)) u_dut_full (
        .clk(clk), .rst(rst), .start(start), .result(result),
        .busy(busy0), .done(done0),
        .led_dau(led_dau0), .led_hund(led_hund0), .led_tens(led_tens0), .led_unit(led_unit0)
    );

    typedef struct {
        logic [7:0] res;
        logic [0:6] dau;
        logic [0:6] hund;
        logic [0:6] tens;
        logic [0:6] unit;
    } vec_t;

    // Active-low patterns: blank=1111111, '-'=1111110
    localparam logic [0:6] BL = 7'b1111111;
    localparam logic [0:6] MI = 7'b1111110;
    localparam logic [0:6] D0 = 7'b0000001;
    localparam logic [0:6] D1 = 7'b1001111;
    localparam logic [0:6] D2 = 7'b0010010;
    localparam logic [0:6] D3 = 7'b0000110;
    localparam logic [0:6] D4 = 7'b1001100;
    localparam logic [0:6] D5 = 7'b0100100;
    localparam logic [0:6] D6 = 7'b0100000;
    localparam logic [0:6] D7 = 7'b0001111;
    localparam logic [0:6] D8 = 7'b0000000;
    localparam logic [0:6] D9 = 7'b0000100;

    vec_t vecs[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_leds(input string name, input vec_t v);
        chk({name, "_dau"},  32'(led_dau),  32'(v.dau));
        chk({name, "_hund"}, 32'(led_hund), 32'(v.hund));
        chk({name, "_tens"}, 32'(led_tens), 32'(v.tens));
        chk({name, "_unit"}, 32'(led_unit), 32'(v.unit));
    endtask

    // Pulses start for one edge, then checks latency, busy window and done pulse width
    task automatic run_conv(input logic [7:0] val, input string name);
        int waits;
        int bcnt;
        result = val;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        waits  = 0;
        bcnt   = 0;
        while (!done && waits < 30) begin
            if (busy) bcnt++;
            tick();
            waits++;
        end
        chk({name, "_latency"}, 32'(waits), 32'd9);
        chk({name, "_busy_cycles"}, 32'(bcnt), 32'd9);
        chk({name, "_busy_at_done"}, 32'(busy), 32'd0);
        tick();
        chk({name, "_done_width"}, 32'(done), 32'd0);
    endtask

    initial begin
        int dcnt;
        vec_t v;

        vecs[0] = '{8'd35,  BL, BL, D3, D5};
        vecs[1] = '{8'h80,  MI, D1, D2, D8};
        vecs[2] = '{8'hF9,  MI, BL, BL, D7};
        vecs[3] = '{8'd0,   BL, BL, BL, D0};
        vecs[4] = '{8'd127, BL, D1, D2, D7};
        vecs[5] = '{8'h9C,  MI, D1, D0, D0};
        vecs[6] = '{8'd10,  BL, BL, D1, D0};
        vecs[7] = '{8'd46,  BL, BL, D4, D6};
        vecs[8] = '{8'd99,  BL, BL, D9, D9};
        vecs[9] = '{8'hFF,  MI, BL, BL, D1};

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk_leds("rst", '{8'd0, BL, BL, BL, BL});
        dcnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done) dcnt++;
        end
        chk("idle_no_done", 32'(dcnt), 32'd0);

        // Vector table
        for (int i = 0; i < 10; i++) begin
            run_conv(vecs[i].res, $sformatf("vec%0d", i));
            chk_leds($sformatf("vec%0d", i), vecs[i]);
        end

        // Leading-zero blanking disabled
        run_conv(8'd5, "full5");
        chk("full5_dau",  32'(led_dau0),  32'(BL));
        chk("full5_hund", 32'(led_hund0), 32'(D0));
        chk("full5_tens", 32'(led_tens0), 32'(D0));
        chk("full5_unit", 32'(led_unit0), 32'(D5));
        run_conv(8'hF9, "full_m7");
        chk("full_m7_dau",  32'(led_dau0),  32'(MI));
        chk("full_m7_hund", 32'(led_hund0), 32'(D0));
        chk("full_m7_unit", 32'(led_unit0), 32'(D7));

        // Start while busy is ignored, as is the result change after capture
        result = 8'd12;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        tick();
        tick();
        result = 8'd99;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) dcnt++;
            tick();
        end
        chk("busy_start_single_done", 32'(dcnt), 32'd1);
        chk_leds("busy_start", '{8'd12, BL, BL, D1, D2});
        run_conv(8'd99, "after_ignore");
        chk_leds("after_ignore", '{8'd99, BL, BL, D9, D9});

        // Reset aborts a conversion in flight
        result = 8'd100;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk_leds("abort", '{8'd0, BL, BL, BL, BL});
        dcnt = 0;
        for (int i = 0; i < 15; i++) begin
            if (done || busy) dcnt++;
            tick();
        end
        chk("abort_no_done", 32'(dcnt), 32'd0);
        run_conv(8'd100, "after_abort");
        chk_leds("after_abort", '{8'd100, BL, D1, D0, D0});

        // Back-to-back: earliest restart one edge after done
        v = '{8'd7, BL, BL, BL, D7};
        run_conv(v.res, "b2b");
        chk_leds("b2b", v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
